// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM handshake state.
package cpu_types_pkg;
    parameter int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// File: rtl/dp_types_pkg.sv
// Datapath-local types for the memory arbiter.
package dp_types_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    localparam int ARB_STARVE_LIMIT = 4;
endpackage

// File: rtl/mem_arb_stats.sv
// Saturating event counter bank for the memory arbiter (built only with MEM_ARB_STATS_EN).
module mem_arb_stats #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             icomp,
    input  logic             dcomp,
    input  logic             istall,
    output logic [CNT_W-1:0] stat_igrants,
    output logic [CNT_W-1:0] stat_dgrants,
    output logic [CNT_W-1:0] stat_istall
);
    localparam int NUM_CNT = 3;

    logic [NUM_CNT-1:0]            inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;

    assign inc = {istall, dcomp, icomp};

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST)
                cnt[g] <= '0;
            else if (inc[g] && cnt[g] != {CNT_W{1'b1}})
                cnt[g] <= cnt[g] + 1'b1;
        end
    end

    assign stat_igrants = cnt[0];
    assign stat_dgrants = cnt[1];
    assign stat_istall  = cnt[2];
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access; data has priority,
// bounded by a starvation counter. Optional statistics under MEM_ARB_STATS_EN.
module mem_arbiter
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic [1:0]        ramstate,
    input  logic [WORD_W-1:0] ramload,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore
`ifdef MEM_ARB_STATS_EN
   ,output logic [CNT_W-1:0]  stat_igrants,
    output logic [CNT_W-1:0]  stat_dgrants,
    output logic [CNT_W-1:0]  stat_istall
`endif
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    arb_state_t      state, state_next, arb_pick;
    ramstate_t       rs;
    logic            dreq, icomp, dcomp;
    logic [SC_W-1:0] starve_cnt, starve_next;

    assign rs    = ramstate_t'(ramstate);
    assign dreq  = dREN | dWEN;
    assign icomp = (state == IGRANT) && (rs == ACCESS) && iREN;
    assign dcomp = (state == DGRANT) && (rs == ACCESS) && dreq;
    assign iwait = iREN & ~icomp;
    assign dwait = dreq & ~dcomp;

    always_comb begin
        starve_next = starve_cnt;
        if (!iREN || icomp)
            starve_next = '0;
        else if (dcomp && starve_cnt != SC_MAX)
            starve_next = starve_cnt + 1'b1;
    end

    // Arbitrate against the post-update count so the limit-th data completion hands over.
    always_comb begin
        arb_pick = IDLE;
        if (iREN && starve_next == SC_MAX)
            arb_pick = IGRANT;
        else if (dreq)
            arb_pick = DGRANT;
        else if (iREN)
            arb_pick = IGRANT;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = arb_pick;
            IGRANT:  if (!iREN || icomp) state_next = arb_pick;
            DGRANT:  if (!dreq || dcomp) state_next = arb_pick;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (icomp) iload = ramload;
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (dcomp) dload = ramload;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    mem_arb_stats #(.CNT_W(CNT_W)) u_stats (
        .CLK          (CLK),
        .nRST         (nRST),
        .icomp        (icomp),
        .dcomp        (dcomp),
        .istall       (iwait),
        .stat_igrants (stat_igrants),
        .stat_dgrants (stat_dgrants),
        .stat_istall  (stat_istall)
    );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter; one row per clock cycle.
module tb_mem_arbiter;
    localparam logic [1:0] RS_F = 2'd0, RS_B = 2'd1, RS_A = 2'd2, RS_E = 2'd3;
    localparam int NV = 31;

    logic        CLK = 1'b0, nRST = 1'b0;
    logic        iREN = 0, dREN = 0, dWEN = 0;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
    logic [1:0]  ramstate = 0;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_igrants, stat_dgrants, stat_istall;
`endif

    int tests = 0, fails = 0;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
`ifdef MEM_ARB_STATS_EN
       ,.stat_igrants(stat_igrants), .stat_dgrants(stat_dgrants), .stat_istall(stat_istall)
`endif
    );

    typedef struct {
        logic        r, i, d, w;
        logic [31:0] ia, da, ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        iw, dw, rr, rw;
        logic [31:0] ra, rst, il, dl;
    } vec_t;

    vec_t v[NV];

    function automatic vec_t mk(input logic r, i, d, w, input logic [31:0] ia, da, ds,
                                input logic [1:0] rs, input logic [31:0] rl,
                                input logic iw, dw, rr, rw, input logic [31:0] ra, rst, il, dl);
        vec_t x;
        x.r = r; x.i = i; x.d = d; x.w = w; x.ia = ia; x.da = da; x.ds = ds; x.rs = rs; x.rl = rl;
        x.iw = iw; x.dw = dw; x.rr = rr; x.rw = rw; x.ra = ra; x.rst = rst; x.il = il; x.dl = dl;
        return x;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        // reset and idle
        v[0]  = mk(0,0,0,0, 0,0,0, RS_F,0,                     0,0,0,0, 0,0,0,0);
        v[1]  = mk(1,0,0,0, 0,0,0, RS_F,0,                     0,0,0,0, 0,0,0,0);
        // instruction fetch, ACCESS on 2nd grant cycle
        v[2]  = mk(1,1,0,0, 32'h40,0,0, RS_F,0,                1,0,0,0, 0,0,0,0);
        v[3]  = mk(1,1,0,0, 32'h40,0,0, RS_B,0,                1,0,1,0, 32'h40,0,0,0);
        v[4]  = mk(1,1,0,0, 32'h40,0,0, RS_A,32'h8C010004,     0,0,1,0, 32'h40,0,32'h8C010004,0);
        v[5]  = mk(1,0,0,0, 0,0,0, RS_F,0,                     0,0,0,0, 0,0,0,0);
        // simultaneous fetch and write: data first
        v[6]  = mk(1,1,0,1, 32'h44,32'h100,32'hDEADBEEF, RS_F,0, 1,1,0,0, 0,0,0,0);
        v[7]  = mk(1,1,0,1, 32'h44,32'h100,32'hDEADBEEF, RS_A,32'h12345678, 1,0,0,1, 32'h100,32'hDEADBEEF,0,32'h12345678);
        v[8]  = mk(1,1,0,0, 32'h44,0,0, RS_F,0,                1,0,0,0, 0,0,0,0);
        v[9]  = mk(1,1,1,0, 32'h44,32'h200,0, RS_A,32'hAAAA0001, 0,1,1,0, 32'h44,0,32'hAAAA0001,0);
        // starvation: 4 data completions, then fetch, then data resumes
        v[10] = mk(1,1,1,0, 32'h48,32'h200,0, RS_A,32'hD0000001, 1,0,1,0, 32'h200,0,0,32'hD0000001);
        v[11] = mk(1,1,1,0, 32'h48,32'h200,0, RS_A,32'hD0000002, 1,0,1,0, 32'h200,0,0,32'hD0000002);
        v[12] = mk(1,1,1,0, 32'h48,32'h200,0, RS_A,32'hD0000003, 1,0,1,0, 32'h200,0,0,32'hD0000003);
        v[13] = mk(1,1,1,0, 32'h48,32'h200,0, RS_A,32'hD0000004, 1,0,1,0, 32'h200,0,0,32'hD0000004);
        v[14] = mk(1,1,1,0, 32'h48,32'h200,0, RS_A,32'h10000048, 0,1,1,0, 32'h48,0,32'h10000048,0);
        v[15] = mk(1,1,1,0, 32'h48,32'h200,0, RS_A,32'hD0000005, 1,0,1,0, 32'h200,0,0,32'hD0000005);
        v[16] = mk(1,0,0,0, 0,0,0, RS_F,0,                     0,0,0,0, 0,0,0,0);
        // fetch withdrawn during BUSY
        v[17] = mk(1,1,0,0, 32'h4C,0,0, RS_F,0,                1,0,0,0, 0,0,0,0);
        v[18] = mk(1,1,0,0, 32'h4C,0,0, RS_B,0,                1,0,1,0, 32'h4C,0,0,0);
        v[19] = mk(1,0,0,0, 32'h4C,0,0, RS_B,32'hBAD00000,     0,0,0,0, 32'h4C,0,0,0);
        v[20] = mk(1,0,0,1, 32'h4C,32'h300,32'hCAFEF00D, RS_F,0, 0,1,0,0, 0,0,0,0);
        // ERROR retries, completion on the 4th cycle
        v[21] = mk(1,0,0,1, 32'h4C,32'h300,32'hCAFEF00D, RS_E,32'hEEEE0000, 0,1,0,1, 32'h300,32'hCAFEF00D,0,0);
        v[22] = mk(1,0,0,1, 32'h4C,32'h300,32'hCAFEF00D, RS_E,32'hEEEE0000, 0,1,0,1, 32'h300,32'hCAFEF00D,0,0);
        v[23] = mk(1,0,0,1, 32'h4C,32'h300,32'hCAFEF00D, RS_E,32'hEEEE0000, 0,1,0,1, 32'h300,32'hCAFEF00D,0,0);
        v[24] = mk(1,0,0,1, 32'h4C,32'h300,32'hCAFEF00D, RS_A,32'h5555AAAA, 0,0,0,1, 32'h300,32'hCAFEF00D,0,32'h5555AAAA);
        // reset mid write
        v[25] = mk(1,0,0,1, 0,32'h304,32'h01234567, RS_B,0,    0,1,0,1, 32'h304,32'h01234567,0,0);
        v[26] = mk(0,0,0,1, 0,32'h304,32'h01234567, RS_B,0,    0,1,0,0, 0,0,0,0);
        v[27] = mk(1,0,0,1, 0,32'h304,32'h01234567, RS_B,0,    0,1,0,0, 0,0,0,0);
        v[28] = mk(1,0,0,1, 0,32'h304,32'h01234567, RS_A,32'h77777777, 0,0,0,1, 32'h304,32'h01234567,0,32'h77777777);
        // read+write together: write wins
        v[29] = mk(1,0,1,1, 0,32'h308,32'h89ABCDEF, RS_F,0,    0,1,0,1, 32'h308,32'h89ABCDEF,0,0);
        v[30] = mk(1,0,0,0, 0,0,0, RS_F,0,                     0,0,0,0, 0,0,0,0);

        for (int k = 0; k < NV; k++) begin
            @(negedge CLK);
            nRST = v[k].r; iREN = v[k].i; dREN = v[k].d; dWEN = v[k].w;
            iaddr = v[k].ia; daddr = v[k].da; dstore = v[k].ds;
            ramstate = v[k].rs; ramload = v[k].rl;
            #1;
            chk("iwait",    k, {31'b0, iwait},  {31'b0, v[k].iw});
            chk("dwait",    k, {31'b0, dwait},  {31'b0, v[k].dw});
            chk("ramREN",   k, {31'b0, ramREN}, {31'b0, v[k].rr});
            chk("ramWEN",   k, {31'b0, ramWEN}, {31'b0, v[k].rw});
            chk("ramaddr",  k, ramaddr,  v[k].ra);
            chk("ramstore", k, ramstore, v[k].rst);
            chk("iload",    k, iload,    v[k].il);
            chk("dload",    k, dload,    v[k].dl);
`ifdef MEM_ARB_STATS_EN
            if (!v[k].r) begin
                chk("stat_igrants_rst", k, {16'b0, stat_igrants}, 32'd0);
                chk("stat_dgrants_rst", k, {16'b0, stat_dgrants}, 32'd0);
                chk("stat_istall_rst",  k, {16'b0, stat_istall},  32'd0);
            end
`endif
        end

`ifdef MEM_ARB_STATS_EN
        // since the last reset: one data completion (row 28), no fetch activity
        @(negedge CLK); #1;
        chk("stat_igrants_end", NV, {16'b0, stat_igrants}, 32'd0);
        chk("stat_dgrants_end", NV, {16'b0, stat_dgrants}, 32'd1);
        chk("stat_istall_end",  NV, {16'b0, stat_istall},  32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
